// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and instruction-fetch port control for the
// RV32IM core. The next PC comes from one of four sources: sequential (PC+4),
// an execute-stage redirect, the trap vector, or hold (stall). Only one fetch
// request is outstanding at a time.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : a redirect target with bits [1:0] != 0 is handled as a trap
//               and Misalign_Err pulses for one cycle.
//   undefined : bits [1:0] of the redirect target are forced to zero and
//               Misalign_Err is always 0.
//
// Ports:
//   Clk_Core, Rst_Core_N       clock, synchronous active-low reset
//   Stall                      decode hazard, hold current fetch result
//   Redirect_Valid/_Target     taken branch/jump from execute
//   Trap_Valid                 trap request, jump to TRAP_VECTOR
//   Imem_Req/Imem_Addr/Imem_Ack instruction memory fetch port
//   Fetch_Valid/Fetch_PC       IF/ID register contents
//   Flush                      one-cycle IF/ID clear pulse
//   Misalign_Err               one-cycle misaligned-redirect pulse
//   Dbg_State                  current FSM state (IDLE/FETCH/HOLD/DRAIN)
//
// Handshake: a fetch is outstanding while Imem_Req=1; the memory completes it
// by asserting Imem_Ack for one cycle. Imem_Ack is ignored while Imem_Req=0.
// The address stays stable until the ack.
module fetch_sequencer #(
  parameter int                 DWIDTH       = 32,
  parameter logic [DWIDTH-1:0]  RESET_VECTOR = DWIDTH'(32'h0000_0000),
  parameter logic [DWIDTH-1:0]  TRAP_VECTOR  = DWIDTH'(32'h0000_0004)
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core_N,
  input  logic              Stall,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_Target,
  input  logic              Trap_Valid,
  output logic              Imem_Req,
  output logic [DWIDTH-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  output logic              Fetch_Valid,
  output logic [DWIDTH-1:0] Fetch_PC,
  output logic              Flush,
  output logic              Misalign_Err,
  output logic [1:0]        Dbg_State
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(32'd4);

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [DWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              req_q, req_d;
  logic              flush_q, flush_d;
  logic              misalign_q, misalign_d;

  logic              ack;
  logic              misaligned;
  logic              take_trap;
  logic [DWIDTH-1:0] redir_tgt;

  assign ack = Imem_Ack & req_q;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = Redirect_Valid && (Redirect_Target[1:0] != 2'b00);
  assign redir_tgt  = Redirect_Target;
`else
  assign misaligned = 1'b0;
  assign redir_tgt  = Redirect_Target & ~DWIDTH'(32'd3);
`endif

  // A misaligned redirect is folded into the trap path.
  assign take_trap = Trap_Valid | misaligned;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drain_addr_d  = drain_addr_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (ack) begin
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b1;
          if (Stall) state_d = ST_HOLD;
          else       pc_d    = pc_q + PC_STEP;
        end else if (!(Stall && fetch_valid_q)) begin
          fetch_valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!Stall) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Wrong-path data is dropped; Fetch_Valid was cleared on entry.
        if (ack) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Control-flow change overrides everything above, including Stall.
    if (state_q != ST_IDLE && (take_trap || Redirect_Valid)) begin
      pc_d          = take_trap ? TRAP_VECTOR : redir_tgt;
      flush_d       = 1'b1;
      misalign_d    = misaligned && !Trap_Valid;
      fetch_valid_d = 1'b0;
      fetch_pc_d    = fetch_pc_q;
      if (state_q == ST_FETCH && !ack) begin
        // Old request still in flight: keep its address on the bus.
        state_d      = ST_DRAIN;
        drain_addr_d = pc_q;
      end else if (state_q == ST_DRAIN && !ack) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end

    req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      drain_addr_q  <= RESET_VECTOR;
      fetch_pc_q    <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      req_q         <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drain_addr_q  <= drain_addr_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      req_q         <= req_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
    end
  end

  assign Imem_Req     = req_q;
  assign Imem_Addr    = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign Fetch_Valid  = fetch_valid_q;
  assign Fetch_PC     = fetch_pc_q;
  assign Flush        = flush_q;
  assign Misalign_Err = misalign_q;
  assign Dbg_State    = state_q;

endmodule
